// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM state encodings, default parameters and stage-control patterns for pipe_ctrl.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int MD_TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF      = 32;

    // {pc, if_id, id_exe, exe_mem, mem_wb enables, if_id, id_exe, exe_mem flushes}
    localparam logic [7:0] CTL_RUN   = 8'b11111_000;
    localparam logic [7:0] CTL_STALL = 8'b00000_000;
    localparam logic [7:0] CTL_MD    = 8'b00001_001;
    localparam logic [7:0] CTL_BR    = 8'b11111_110;
    localparam logic [7:0] CTL_LU    = 8'b00111_010;
    localparam logic [7:0] CTL_RST   = 8'b00000_111;
endpackage

// File: rtl/pipe_ctrl_md_watchdog.sv
// md_watchdog: counts cycles spent waiting on muldiv and flags the MD_TIMEOUT-th one.
module md_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int W = $clog2(MD_TIMEOUT + 1);

    logic [W-1:0] cnt;

    // expire is combinational so the controller can end the wait in the same cycle
    assign expire = run && (cnt == W'(MD_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (run)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush controller with muldiv and dmem wait handling.
// Optional perf counters (stall_cycles, flush_cycles) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_req,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             exe_mem_flush,
    output logic             md_go,
    output logic             md_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
`endif
);
    state_t     state, nxt;
    logic [7:0] ctl;
    logic       expire;
    logic       stall;
    logic       md_end;

    md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_md_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != MD_WAIT),
        .run    (state == MD_WAIT),
        .expire (expire)
    );

    assign {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
            if_id_flush, id_exe_flush, exe_mem_flush} = ctl;

    // Once in MEM_WAIT the request is already outstanding, so only mem_ready matters
    assign stall  = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    assign md_end = md_done || expire;

    always_comb begin
        ctl   = CTL_RUN;
        md_go = 1'b0;
        nxt   = RUN;
        if (!rst_n) begin
            ctl = CTL_RST;
        end else if (state == MD_WAIT) begin
            ctl = md_end ? CTL_RUN : CTL_MD;
            nxt = md_end ? RUN : MD_WAIT;
        end else if (stall) begin
            ctl = CTL_STALL;
            nxt = MEM_WAIT;
        end else if (md_start) begin
            ctl   = CTL_MD;
            md_go = 1'b1;
            nxt   = MD_WAIT;
        end else begin
            ctl = br_taken ? CTL_BR : (load_use_req ? CTL_LU : CTL_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            md_timeout <= 1'b0;
        end else begin
            state <= nxt;
            if (state == MD_WAIT && expire && !md_done)
                md_timeout <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_en && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (if_id_flush && !(&flush_cycles))
                flush_cycles <= flush_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; each row drives one cycle and queues its expected controls.
module tb_pipe_ctrl;
    // stimulus {rst_n, load_use_req, md_start, md_done, mem_req, mem_ready, br_taken}
    localparam logic [6:0] S_RST  = 7'b0000000;
    localparam logic [6:0] S_IDLE = 7'b1000000;
    localparam logic [6:0] S_LU   = 7'b1100000;
    localparam logic [6:0] S_MS   = 7'b1010000;
    localparam logic [6:0] S_MD   = 7'b1001000;
    localparam logic [6:0] S_MSD  = 7'b1011000;
    localparam logic [6:0] S_MQ   = 7'b1000100;
    localparam logic [6:0] S_MQR  = 7'b1000110;
    localparam logic [6:0] S_BR   = 7'b1000001;
    localparam logic [6:0] S_BRLU = 7'b1100001;
    // expected {pc,if_id,id_exe,exe_mem,mem_wb en, if_id,id_exe,exe_mem flush, md_go}
    localparam logic [8:0] E_RUN = 9'b11111_000_0;
    localparam logic [8:0] E_STL = 9'b00000_000_0;
    localparam logic [8:0] E_MDG = 9'b00001_001_1;
    localparam logic [8:0] E_MDW = 9'b00001_001_0;
    localparam logic [8:0] E_BR  = 9'b11111_110_0;
    localparam logic [8:0] E_LU  = 9'b00111_010_0;
    localparam logic [8:0] E_RST = 9'b00000_111_0;

    logic clk = 1'b0;
    logic rst_n, load_use_req, md_start, md_done, mem_req, mem_ready, br_taken;
    logic pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic if_id_flush, id_exe_flush, exe_mem_flush, md_go, md_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif
    logic [9:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MD_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use_req  (load_use_req),
        .md_start      (md_start),
        .md_done       (md_done),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .br_taken      (br_taken),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_exe_en     (id_exe_en),
        .exe_mem_en    (exe_mem_en),
        .mem_wb_en     (mem_wb_en),
        .if_id_flush   (if_id_flush),
        .id_exe_flush  (id_exe_flush),
        .exe_mem_flush (exe_mem_flush),
        .md_go         (md_go),
        .md_timeout    (md_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_cycles  (flush_cycles)
`endif
    );

    wire [9:0] obs = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                      if_id_flush, id_exe_flush, exe_mem_flush, md_go, md_timeout};

    task automatic drive(input logic [6:0] s);
        @(posedge clk);
        #1;
        {rst_n, load_use_req, md_start, md_done, mem_req, mem_ready, br_taken} = s;
    endtask

    task automatic test_reset();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_RST, E_RST, 1'b0}, {S_RST, E_RST, 1'b0}, {S_IDLE, E_RUN, 1'b0}, {S_MD, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_load_use();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_IDLE, E_RUN, 1'b0}, {S_LU, E_LU, 1'b0}, {S_IDLE, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_branch();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_BRLU, E_BR, 1'b0}, {S_BR, E_BR, 1'b0}, {S_IDLE, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL branch[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_MS, E_MDG, 1'b0}, {S_MS, E_MDW, 1'b0}, {S_MS, E_MDW, 1'b0}, {S_MS, E_MDW, 1'b0},
              {S_MS, E_MDW, 1'b0}, {S_MSD, E_RUN, 1'b0}, {S_IDLE, E_RUN, 1'b0}, {S_MD, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL muldiv[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_mem();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_MQ, E_STL, 1'b0}, {S_MQ, E_STL, 1'b0}, {S_MQ, E_STL, 1'b0},
              {S_MQR, E_RUN, 1'b0}, {S_IDLE, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL mem[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_priority();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{7'b1110101, E_STL, 1'b0}, {7'b1110111, E_MDG, 1'b0}, {S_MD, E_RUN, 1'b0},
              {7'b1010001, E_MDG, 1'b0}, {S_MD, E_RUN, 1'b0}, {S_IDLE, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL priority[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_LU, E_LU, 1'b0}, {S_LU, E_LU, 1'b0}, {S_LU, E_LU, 1'b0}, {S_BR, E_BR, 1'b0}, {S_IDLE, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_MS, E_MDG, 1'b0}};
        for (int k = 0; k < 7; k++) t.push_back({S_IDLE, E_MDW, 1'b0});
        t.push_back({S_IDLE, E_RUN, 1'b0});
        t.push_back({S_IDLE, E_RUN, 1'b1});
        t.push_back({S_IDLE, E_RUN, 1'b1});
        t.push_back({S_LU, E_LU, 1'b1});
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

    task automatic test_reset_md();
        logic [16:0] t [$];
        logic [9:0] want;
        t = '{{S_MS, E_MDG, 1'b1}, {S_IDLE, E_MDW, 1'b1}, {S_RST, E_RST, 1'b1},
              {S_IDLE, E_RUN, 1'b0}, {S_MD, E_RUN, 1'b0}, {S_IDLE, E_RUN, 1'b0}};
        foreach (t[i]) begin
            drive(t[i][16:10]);
            exp_q.push_back(t[i][9:0]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset_md[%0d]: got %b want %b", i, obs, want);
            end
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        drive(S_RST);
        drive(S_IDLE);
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, flush_cycles);
        end
        drive(S_LU);
        drive(S_LU);
        drive(S_BR);
        drive(S_IDLE);
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd2 || flush_cycles !== 32'd1) begin
            errors++;
            $display("FAIL perf_count: got %0d/%0d want 2/1", stall_cycles, flush_cycles);
        end
    endtask
`endif

    initial begin
        {rst_n, load_use_req, md_start, md_done, mem_req, mem_ready, br_taken} = S_RST;
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_mem();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_md();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64: max cycles in MD_WAIT before abort.
REQ-002 SHALL have parameter CNT_W, default 32: perf counter width.
REQ-003 SHALL have clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have load_use_req, input, 1: ID consumer depends on EXE load.
REQ-006 SHALL have md_start, input, 1: EXE holds MUL/DIV op, level, held until accepted.
REQ-007 SHALL have md_done, input, 1: muldiv result valid, single-cycle pulse.
REQ-008 SHALL have mem_req and mem_ready, inputs, 1 each: MEM-stage dmem access, and its completion.
REQ-009 SHALL have br_taken, input, 1: EXE resolved taken branch/jump.
REQ-010 SHALL have pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, outputs, 1 each: register enables.
REQ-011 SHALL have if_id_flush, id_exe_flush, exe_mem_flush, outputs, 1 each: bubble insert (flush overrides enable).
REQ-012 SHALL have md_go, output, 1: one-cycle launch pulse to muldiv.
REQ-013 SHALL have md_timeout, output, 1: sticky abort flag.

Function
REQ-014 SHALL keep registered FSM states RUN, MD_WAIT, MEM_WAIT; outputs combinational from state and inputs.
REQ-015 SHALL, in RUN with no event, drive all enables 1, all flushes 0.
REQ-016 SHALL apply priority: mem stall > md_start > br_taken > load_use_req.
REQ-017 SHALL, on mem_req && !mem_ready in RUN, drive all enables 0 and go MEM_WAIT.
REQ-018 SHALL, in MEM_WAIT, hold all enables 0 while !mem_ready; on mem_ready, apply RUN rules that cycle with the mem stall satisfied and take the next state those rules select.
REQ-019 SHALL, on md_start in RUN, pulse md_go for exactly that cycle, drive pc_en/if_id_en/id_exe_en/exe_mem_en 0, mem_wb_en 1, exe_mem_flush 1, and go MD_WAIT.
REQ-020 SHALL, in MD_WAIT, repeat REQ-019 outputs except md_go=0; on md_done, drive all enables 1, flushes 0, and go RUN.
REQ-021 SHALL ignore md_done outside MD_WAIT; md_done is accepted no earlier than the cycle after md_go.
REQ-022 SHALL count MD_WAIT cycles; at MD_TIMEOUT without md_done, set md_timeout, treat as done (REQ-020), and return RUN.
REQ-023 SHALL, on br_taken, drive if_id_flush=1, id_exe_flush=1, all enables 1; simultaneous load_use_req is ignored.
REQ-024 SHALL, on load_use_req alone, drive pc_en=0, if_id_en=0, id_exe_flush=1, others 1 (one bubble per asserted cycle).
REQ-025 SHALL treat md_start && br_taken as illegal; md_start wins.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, force state RUN, timeout counter 0, md_timeout 0, perf counters 0.
REQ-027 SHALL, while rst_n=0, drive all enables 0, all flushes 1, md_go 0.
REQ-028 SHALL abort any MD_WAIT/MEM_WAIT on reset without issuing md_go.

Configuration
REQ-029 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs stall_cycles and flush_cycles [CNT_W-1:0]: cycles with pc_en=0, cycles with if_id_flush=1, counting only while rst_n=1, saturating at all-ones.
REQ-030 SHALL, without PIPE_CTRL_PERF_EN, omit those ports and counters entirely.

Structure
REQ-031 SHALL place FSM state encodings and MD_TIMEOUT default in common.vh.
REQ-032 SHALL implement the MD_WAIT counter as sub-module md_watchdog (clear, run, expire).

Verification
REQ-033 load_use_req=1 one cycle -> pc_en=0, if_id_en=0, id_exe_flush=1 that cycle only.
REQ-034 md_start held, md_done 5 cycles after md_go -> md_go one cycle, 5 cycles exe_mem_flush=1, then all enables 1.
REQ-035 MD_TIMEOUT=8, no md_done -> md_timeout=1 after 8 MD_WAIT cycles, state RUN, flag sticky until reset.
REQ-036 br_taken=1 with load_use_req=1 -> if_id_flush=id_exe_flush=1, pc_en=1.
REQ-037 mem_req=1, mem_ready low 3 cycles -> all enables 0 for 3 cycles, enables 1 on ready cycle.
REQ-038 rst_n=0 during MD_WAIT -> next cycle state RUN, md_go=0, counters 0.
